// File: rtl/cpu16_pkg.sv
// Shared CPU16 definitions: HALT opcode, PC step, fetch-queue entry layout
// and the fetch halt-state encoding.
package cpu16_pkg;

  localparam logic [15:0] HALT_OPCODE = 16'hFFFF;
  localparam logic [15:0] PC_INCR     = 16'd2;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALTED
  } fetch_state_t;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Parameterised circular buffer of fetch entries with a single-cycle flush.
// A pop in the same cycle as a flush is absorbed, because the flush empties everything anyway.
module fetch_queue
  import cpu16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         valid,
  output logic         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_COUNT = CW'(DEPTH);

  fetch_entry_t    entries [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign valid   = (count != '0);
  assign full    = (count == DEPTH_COUNT);
  assign head    = entries[rd_ptr];
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push) begin
      entries[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, fetch queue toward decode, redirect flush.
// Optional HALT detection is built only when FETCH_HALT_EN is defined.
module fetch_unit
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] IM_Addr,
  input  logic [15:0] IM_Instr,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [15:0] OutInstr,
  output logic [15:0] OutPC,
  output logic        Halted
);

  logic [15:0]  pc;
  logic         halted;
  logic         transfer;
  logic         fetch_en;
  logic         queue_full;
  fetch_entry_t head;
  fetch_entry_t fetch_entry;

  assign IM_Addr     = pc;
  assign transfer    = OutValid && OutReady;
  assign fetch_en    = !Redirect && !halted && (!queue_full || transfer);
  assign fetch_entry = '{pc: pc, instr: IM_Instr};
  assign OutInstr    = head.instr;
  assign OutPC       = head.pc;
  assign Halted      = halted;

  // PC wraps modulo 2^16; redirect targets are taken verbatim, odd or not.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc <= RESET_PC;
    end else if (Redirect) begin
      pc <= RedirectPC;
    end else if (fetch_en) begin
      pc <= pc + PC_INCR;
    end
  end

`ifdef FETCH_HALT_EN
  fetch_state_t state_q;
  fetch_state_t state_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= FETCH_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // fetch_en already excludes Redirect, so only HALTED needs to watch for it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_RUN:    if (fetch_en && is_halt(IM_Instr)) state_d = FETCH_HALTED;
      FETCH_HALTED: if (Redirect) state_d = FETCH_RUN;
      default:      state_d = FETCH_RUN;
    endcase
  end

  assign halted = (state_q == FETCH_HALTED);
`else
  assign halted = 1'b0;
`endif

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clock    (Clock),
    .reset    (Reset),
    .flush    (Redirect),
    .push     (fetch_en),
    .push_data(fetch_entry),
    .pop      (transfer),
    .head     (head),
    .valid    (OutValid),
    .full     (queue_full)
  );

endmodule
